// File: rtl/pattern_entry_checker_if.sv
// Bus between the light-pattern game top level and pattern_entry_checker.
//   master: drives load, pattern, btn; observes the result outputs.
//   slave : the checker; consumes load/pattern/btn, drives ready, pass, fail,
//           timed_out, step and the LD3..LD0 echo LEDs.
interface pattern_entry_checker_if #(
    parameter int unsigned SEQ_LEN = 4,
    parameter int unsigned STEP_W  = 2
);
    logic                   load;
    logic [2*SEQ_LEN-1:0]   pattern;
    logic [3:0]             btn;
    logic                   ready;
    logic                   pass;
    logic                   fail;
    logic                   timed_out;
    logic [STEP_W-1:0]      step;
    logic                   LD3;
    logic                   LD2;
    logic                   LD1;
    logic                   LD0;

    modport master (
        output load, pattern, btn,
        input  ready, pass, fail, timed_out, step, LD3, LD2, LD1, LD0
    );

    modport slave (
        input  load, pattern, btn,
        output ready, pass, fail, timed_out, step, LD3, LD2, LD1, LD0
    );
endinterface

// File: rtl/pattern_entry_checker.sv
// Player-input side of the light-pattern game. Captures the pattern shown on
// LD3..LD0, synchronises and edge-detects the raw buttons, and checks each
// accepted press against the stored pattern step by step.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - pattern_entry_checker_if.slave:
//              load (1-cycle restart pulse), pattern (2 bits per step),
//              btn (raw async buttons), ready, pass, fail, timed_out,
//              step (next expected step), LD3..LD0 (echo of last press)
//
// Optional feature: define PATTERN_CHECK_TIMEOUT_EN to fail a step that sees
// no press within TIMEOUT_CYCLES ARMED cycles. Without it ARMED waits forever
// and timed_out is tied low.
module pattern_entry_checker #(
    parameter int unsigned SEQ_LEN        = 4,
    parameter int unsigned STEP_W         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                    clk,
    input logic                    reset,
    pattern_entry_checker_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitRel,
        StArmed,
        StPass,
        StFail
    } state_e;

    state_e               state_q;
    logic [3:0]           s0_q;
    logic [3:0]           s1_q;
    logic [3:0]           prev_q;
    logic [2*SEQ_LEN-1:0] pat_q;
    logic [STEP_W-1:0]    step_q;
    logic [3:0]           ld_q;
    logic                 ready_q;
    logic                 pass_q;
    logic                 fail_q;

    logic                 ev;
    logic                 one_hot;
    logic                 match;
    logic [1:0]           press_idx;
    logic [1:0]           exp_idx;

    always_comb begin
        ev      = (s1_q != 4'd0) && (prev_q == 4'd0);
        one_hot = (s1_q != 4'd0) && ((s1_q & (s1_q - 4'd1)) == 4'd0);
        press_idx = 2'd0;
        case (s1_q)
            4'b0010: press_idx = 2'd1;
            4'b0100: press_idx = 2'd2;
            4'b1000: press_idx = 2'd3;
            default: press_idx = 2'd0;
        endcase
        exp_idx = pat_q[{step_q, 1'b0} +: 2];
        match   = one_hot && (press_idx == exp_idx);
    end

`ifdef PATTERN_CHECK_TIMEOUT_EN
    logic [31:0] timer_q;
    logic        timed_out_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s0_q    <= '0;
            s1_q    <= '0;
            prev_q  <= '0;
            pat_q   <= '0;
            step_q  <= '0;
            ld_q    <= '0;
            ready_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
`ifdef PATTERN_CHECK_TIMEOUT_EN
            timer_q     <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            s0_q   <= bus.btn;
            s1_q   <= s0_q;
            prev_q <= s1_q;
            if (bus.load) begin
                // A press landing on the same edge is dropped here.
                pat_q   <= bus.pattern;
                step_q  <= '0;
                ld_q    <= '0;
                ready_q <= 1'b0;
                pass_q  <= 1'b0;
                fail_q  <= 1'b0;
`ifdef PATTERN_CHECK_TIMEOUT_EN
                timed_out_q <= 1'b0;
`endif
                state_q <= StWaitRel;
            end else begin
                case (state_q)
                    StWaitRel: begin
                        // Require all buttons released so a held press never counts twice.
                        if (s1_q == 4'd0) begin
                            state_q <= StArmed;
                            ready_q <= 1'b1;
`ifdef PATTERN_CHECK_TIMEOUT_EN
                            timer_q <= '0;
`endif
                        end
                    end
                    StArmed: begin
                        if (ev) begin
                            ready_q <= 1'b0;
                            if (!one_hot) begin
                                fail_q  <= 1'b1;
                                state_q <= StFail;
                            end else if (!match) begin
                                ld_q    <= s1_q;
                                fail_q  <= 1'b1;
                                state_q <= StFail;
                            end else if (step_q == STEP_W'(SEQ_LEN - 1)) begin
                                ld_q    <= s1_q;
                                pass_q  <= 1'b1;
                                state_q <= StPass;
                            end else begin
                                ld_q    <= s1_q;
                                step_q  <= step_q + 1'b1;
                                state_q <= StWaitRel;
                            end
`ifdef PATTERN_CHECK_TIMEOUT_EN
                        end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                            ready_q     <= 1'b0;
                            fail_q      <= 1'b1;
                            timed_out_q <= 1'b1;
                            state_q     <= StFail;
                        end else begin
                            timer_q <= timer_q + 32'd1;
`endif
                        end
                    end
                    default: ;  // IDLE, PASS, FAIL hold until load
                endcase
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.pass  = pass_q;
    assign bus.fail  = fail_q;
    assign bus.step  = step_q;
    assign bus.LD3   = ld_q[3];
    assign bus.LD2   = ld_q[2];
    assign bus.LD1   = ld_q[1];
    assign bus.LD0   = ld_q[0];
`ifdef PATTERN_CHECK_TIMEOUT_EN
    assign bus.timed_out = timed_out_q;
`else
    assign bus.timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_entry_checker.sv
// Bench for pattern_entry_checker: directed scenarios plus randomized press
// sequences checked against a step-list reference model.
module tb_pattern_entry_checker;

    localparam int SEQ_LEN = 4;
    localparam int STEP_W  = 2;
    localparam int TO      = 20;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    pattern_entry_checker_if #(.SEQ_LEN(SEQ_LEN), .STEP_W(STEP_W)) bus ();

    pattern_entry_checker #(
        .SEQ_LEN        (SEQ_LEN),
        .STEP_W         (STEP_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Status word: {ready, pass, fail, timed_out, step[1:0], LD3..LD0}
    function automatic logic [9:0] got();
        return {bus.ready, bus.pass, bus.fail, bus.timed_out, bus.step,
                bus.LD3, bus.LD2, bus.LD1, bus.LD0};
    endfunction

    function automatic logic [9:0] st(logic r, logic p, logic f, logic t,
                                      logic [1:0] s, logic [3:0] ld);
        return {r, p, f, t, s, ld};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] pat);
        bus.pattern = pat;
        bus.load    = 1'b1;
        tick();
        bus.load    = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        bus.btn = v;
        repeat (3) tick();
        bus.btn = 4'd0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [9:0] e;
        reset = 1'b1;
        bus.load = 1'b0;
        bus.pattern = 8'h00;
        bus.btn = 4'($urandom_range(1, 15));
        tick();
        tick();
        e = st(0, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL reset_state: got %b exp %b", got(), e);
        end
        reset = 1'b0;
        bus.btn = 4'd0;
        tick();
        press(4'b0100);
        press(4'b0001);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL idle_ignores_btn: got %b exp %b", got(), e);
        end
    endtask

    task automatic test_correct_sequence();
        logic [9:0] e;
        do_load(8'b11_01_00_10);
        tick();
        e = st(1, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL armed_after_load: got %b exp %b", got(), e);
        end
        press(4'b0100);
        e = st(1, 0, 0, 0, 2'd1, 4'b0100);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL seq_step1: got %b exp %b", got(), e);
        end
        press(4'b0001);
        press(4'b0010);
        e = st(1, 0, 0, 0, 2'd3, 4'b0010);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL seq_step3: got %b exp %b", got(), e);
        end
        press(4'b1000);
        e = st(0, 1, 0, 0, 2'd3, 4'b1000);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL seq_pass: got %b exp %b", got(), e);
        end
        press(4'b0100);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL pass_holds: got %b exp %b", got(), e);
        end
    endtask

    task automatic test_wrong_press();
        logic [9:0] e;
        do_load(8'b11_01_00_10);
        tick();
        press(4'b0100);
        bus.btn = 4'b0010;
        tick();
        tick();
        e = st(1, 0, 0, 0, 2'd1, 4'b0100);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL wrong_press_latency: got %b exp %b", got(), e);
        end
        tick();
        e = st(0, 0, 1, 0, 2'd1, 4'b0010);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL wrong_press_fail: got %b exp %b", got(), e);
        end
        bus.btn = 4'd0;
        repeat (4) tick();
    endtask

    task automatic test_held_load();
        logic [9:0] e;
        bus.btn = 4'b0100;
        repeat (3) tick();
        do_load(8'b11_01_00_10);
        repeat (5) tick();
        e = st(0, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL held_waitrel: got %b exp %b", got(), e);
        end
        bus.btn = 4'd0;
        tick();
        tick();
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL held_release_early: got %b exp %b", got(), e);
        end
        tick();
        e = st(1, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL held_release_armed: got %b exp %b", got(), e);
        end
    endtask

    task automatic test_multi_press();
        logic [9:0] e;
        do_load(8'b11_01_00_10);
        tick();
        press(4'b0101);
        e = st(0, 0, 1, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL multi_press_fail: got %b exp %b", got(), e);
        end
        do_load(8'b11_01_00_10);
        e = st(0, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL load_clears_fail: got %b exp %b", got(), e);
        end
        tick();
        e = st(1, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL reload_ready: got %b exp %b", got(), e);
        end
    endtask

    task automatic test_load_priority();
        logic [9:0] e;
        do_load(8'b11_01_00_10);
        tick();
        bus.btn = 4'b0100;  // correct first step, timed to meet the load
        tick();
        tick();
        do_load(8'b11_01_00_10);
        e = st(0, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL load_beats_press: got %b exp %b", got(), e);
        end
        bus.btn = 4'd0;
        repeat (4) tick();
        e = st(1, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL press_discarded: got %b exp %b", got(), e);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        do_load(8'b11_01_00_10);
        tick();
        press(4'b0100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e = st(0, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL reset_mid: got %b exp %b", got(), e);
        end
        press(4'b0001);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL reset_mid_idle: got %b exp %b", got(), e);
        end
    endtask

    task automatic test_random();
        logic [1:0] steps[SEQ_LEN];
        logic [7:0] pat;
        logic [3:0] v;
        logic [3:0] ld;
        logic       p;
        logic       f;
        int         idx;
        int         nidx;
        logic [9:0] e;
        for (int it = 0; it < 30; it++) begin
            pat = 8'($urandom);
            for (int k = 0; k < SEQ_LEN; k++) steps[k] = pat[2*k +: 2];
            do_load(pat);
            tick();
            idx = 0;
            ld = 4'd0;
            p = 1'b0;
            f = 1'b0;
            for (int n = 0; n < SEQ_LEN + 2; n++) begin
                if ($urandom_range(0, 3) != 0)
                    v = 4'(1 << steps[idx]);
                else
                    v = 4'($urandom_range(1, 15));
                press(v);
                if (!p && !f) begin
                    if ($countones(v) != 1) begin
                        f = 1'b1;
                    end else begin
                        nidx = $clog2(v);
                        ld = v;
                        if (nidx != int'(steps[idx])) f = 1'b1;
                        else if (idx == SEQ_LEN - 1) p = 1'b1;
                        else idx++;
                    end
                end
                e = st(!(p || f), p, f, 1'b0, 2'(idx), ld);
                n_vec++;
                if (got() !== e) begin
                    n_err++;
                    $display("FAIL random it%0d press%0d btn=%b: got %b exp %b",
                             it, n, v, got(), e);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        do_load(8'b11_01_00_10);
        tick();
`ifdef PATTERN_CHECK_TIMEOUT_EN
        repeat (TO - 1) tick();
        e = st(1, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL timeout_early: got %b exp %b", got(), e);
        end
        tick();
        e = st(0, 0, 1, 1, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL timeout_fire: got %b exp %b", got(), e);
        end
`else
        repeat (3 * TO) tick();
        e = st(1, 0, 0, 0, 2'd0, 4'd0);
        n_vec++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL no_timeout: got %b exp %b", got(), e);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_correct_sequence();
        test_wrong_press();
        test_held_load();
        test_multi_press();
        test_load_priority();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
